// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one lc3b memory port between the instruction-fetch
// requester (read-only) and the data requester (read/write). The winning
// request is captured into registers and driven to memory until mem_resp;
// the response is routed back to the granted requester only.
module mem_arbiter #(
    parameter int DATA_PRIORITY = 0  // 0: round-robin on ties, 1: data always wins ties
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_read,
    input  logic [15:0] i_address,
    output logic        i_resp,
    output logic [15:0] i_rdata,

    input  logic        d_read,
    input  logic        d_write,
    input  logic [15:0] d_address,
    input  logic [15:0] d_wdata,
    input  logic [1:0]  d_byte_enable,
    output logic        d_resp,
    output logic [15:0] d_rdata,

    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_byte_enable,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t      state_q, state_d;
    grant_t      last_q, last_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;
    logic        write_q, write_d;

    logic        inst_req;
    logic        data_req;
    logic        pick_data;

    assign inst_req = i_read;
    assign data_req = d_read | d_write;

    // Tie-break: data wins under fixed priority, otherwise the port not served last.
    assign pick_data = data_req & (~inst_req | (DATA_PRIORITY != 0) | (last_q == GRANT_I));

    // State and captured-request registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= GRANT_I;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            be_q    <= 2'b00;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            write_q <= write_d;
        end
    end

    // Next-state: grant from IDLE and capture the request; return to IDLE on mem_resp.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        write_d = write_q;

        unique case (state_q)
            IDLE: begin
                if (pick_data) begin
                    state_d = SERVE_D;
                    last_d  = GRANT_D;
                    addr_d  = d_address;
                    wdata_d = d_wdata;
                    // A simultaneous read+write is issued as a write.
                    write_d = d_write;
                    be_d    = d_write ? d_byte_enable : 2'b11;
                end else if (inst_req) begin
                    state_d = SERVE_I;
                    last_d  = GRANT_I;
                    addr_d  = i_address;
                    wdata_d = 16'h0000;
                    write_d = 1'b0;
                    be_d    = 2'b11;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory strobes follow the serve state; responses go only to the granted port.
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        i_resp          = 1'b0;
        d_resp          = 1'b0;
        i_rdata         = 16'h0000;
        d_rdata         = 16'h0000;
        mem_address     = addr_q;
        mem_wdata       = wdata_q;
        mem_byte_enable = be_q;

        if (state_q == SERVE_I) begin
            mem_read = 1'b1;
            if (mem_resp) begin
                i_resp  = 1'b1;
                i_rdata = mem_rdata;
            end
        end else if (state_q == SERVE_D) begin
            mem_read  = ~write_q;
            mem_write = write_q;
            if (mem_resp) begin
                d_resp  = 1'b1;
                d_rdata = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two instances (round-robin and data-priority),
// a latency-configurable memory responder, a transaction-level reference
// model compared on every cycle, and directed scenarios with literal values.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        i_read        [2];
    logic [15:0] i_address     [2];
    logic        i_resp        [2];
    logic [15:0] i_rdata       [2];
    logic        d_read        [2];
    logic        d_write       [2];
    logic [15:0] d_address     [2];
    logic [15:0] d_wdata       [2];
    logic [1:0]  d_byte_enable [2];
    logic        d_resp        [2];
    logic [15:0] d_rdata       [2];
    logic        mem_read      [2];
    logic        mem_write     [2];
    logic [15:0] mem_address   [2];
    logic [15:0] mem_wdata     [2];
    logic [1:0]  mem_byte_enable [2];
    logic        mem_resp      [2];
    logic [15:0] mem_rdata     [2];

    // memory responder controls
    logic        auto_en   [2];
    logic        man_resp  [2];
    logic        auto_r    [2] = '{1'b0, 1'b0};
    int          wcnt      [2] = '{0, 0};
    logic        use_fixed;
    logic [15:0] fixed_rdata;

    // reference model: who is being served and the captured transaction
    int          m_cur   [2] = '{0, 0};   // 0 none, 1 instruction, 2 data
    int          m_last  [2] = '{1, 1};   // 1 instruction, 2 data
    logic [15:0] m_addr  [2] = '{16'h0, 16'h0};
    logic [15:0] m_wdata [2] = '{16'h0, 16'h0};
    logic [1:0]  m_be    [2] = '{2'b0, 2'b0};
    logic        m_wr    [2] = '{1'b0, 1'b0};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.DATA_PRIORITY(g)) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .i_read          (i_read[g]),
            .i_address       (i_address[g]),
            .i_resp          (i_resp[g]),
            .i_rdata         (i_rdata[g]),
            .d_read          (d_read[g]),
            .d_write         (d_write[g]),
            .d_address       (d_address[g]),
            .d_wdata         (d_wdata[g]),
            .d_byte_enable   (d_byte_enable[g]),
            .d_resp          (d_resp[g]),
            .d_rdata         (d_rdata[g]),
            .mem_read        (mem_read[g]),
            .mem_write       (mem_write[g]),
            .mem_address     (mem_address[g]),
            .mem_wdata       (mem_wdata[g]),
            .mem_byte_enable (mem_byte_enable[g]),
            .mem_resp        (mem_resp[g]),
            .mem_rdata       (mem_rdata[g])
        );
    end

    // memory side: response source and read data (address-derived unless fixed)
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            mem_resp[g]  = auto_en[g] ? auto_r[g] : man_resp[g];
            mem_rdata[g] = use_fixed ? fixed_rdata : (mem_address[g] ^ 16'hA5A5);
        end
    end

    // automatic responder: answers after three waiting cycles of a strobe
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (auto_en[g] && (mem_read[g] || mem_write[g]) && !auto_r[g]) begin
                if (wcnt[g] == 2) begin
                    auto_r[g] <= 1'b1;
                    wcnt[g]   <= 0;
                end else begin
                    wcnt[g] <= wcnt[g] + 1;
                end
            end else begin
                auto_r[g] <= 1'b0;
                wcnt[g]   <= 0;
            end
        end
    end

    // which requester the arbitration rules grant when nobody is being served
    function automatic int pick(input int g);
        bit ir;
        bit dr;
        ir = i_read[g];
        dr = d_read[g] | d_write[g];
        if (ir && dr) return ((g != 0) || (m_last[g] == 1)) ? 2 : 1;
        if (dr) return 2;
        if (ir) return 1;
        return 0;
    endfunction

    // reference model update
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < 2; g++) begin
                m_cur[g]   <= 0;
                m_last[g]  <= 1;
                m_addr[g]  <= 16'h0;
                m_wdata[g] <= 16'h0;
                m_be[g]    <= 2'b00;
                m_wr[g]    <= 1'b0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (m_cur[g] == 0) begin
                    case (pick(g))
                        1: begin
                            m_cur[g]   <= 1;
                            m_last[g]  <= 1;
                            m_addr[g]  <= i_address[g];
                            m_wdata[g] <= 16'h0;
                            m_be[g]    <= 2'b11;
                            m_wr[g]    <= 1'b0;
                        end
                        2: begin
                            m_cur[g]   <= 2;
                            m_last[g]  <= 2;
                            m_addr[g]  <= d_address[g];
                            m_wdata[g] <= d_wdata[g];
                            m_be[g]    <= d_write[g] ? d_byte_enable[g] : 2'b11;
                            m_wr[g]    <= d_write[g];
                        end
                        default: ;
                    endcase
                end else if (mem_resp[g]) begin
                    m_cur[g] <= 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int g, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d got=%h expected=%h t=%0t", nm, g, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < 2; g++) begin
            logic ir, dr;
            ir = (m_cur[g] == 1) && mem_resp[g];
            dr = (m_cur[g] == 2) && mem_resp[g];
            chk("mem_read",  g, 16'(mem_read[g]),  16'((m_cur[g] != 0) && !m_wr[g]));
            chk("mem_write", g, 16'(mem_write[g]), 16'((m_cur[g] != 0) && m_wr[g]));
            chk("mem_address", g, mem_address[g], m_addr[g]);
            chk("mem_wdata", g, mem_wdata[g], m_wdata[g]);
            chk("mem_be",    g, 16'(mem_byte_enable[g]), 16'(m_be[g]));
            chk("i_resp",    g, 16'(i_resp[g]), 16'(ir));
            chk("d_resp",    g, 16'(d_resp[g]), 16'(dr));
            chk("i_rdata",   g, i_rdata[g], ir ? mem_rdata[g] : 16'h0);
            chk("d_rdata",   g, d_rdata[g], dr ? mem_rdata[g] : 16'h0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    // wait (bounded) for a response pulse on instance g; who: 1 inst, 2 data, 3 both
    task automatic wait_resp(input int g, output int who, output logic [15:0] rd);
        who = 0;
        rd  = 16'h0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            compare_all();
            if (i_resp[g] || d_resp[g]) begin
                who = (i_resp[g] && d_resp[g]) ? 3 : (i_resp[g] ? 1 : 2);
                rd  = i_resp[g] ? i_rdata[g] : d_rdata[g];
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_resp(input int g, input int ewho, input logic [15:0] erd, input string nm);
        int who;
        logic [15:0] rd;
        wait_resp(g, who, rd);
        chk({nm, "_who"}, g, 16'(who), 16'(ewho));
        chk({nm, "_rdata"}, g, rd, erd);
    endtask

    initial begin
        rst_n       = 1'b0;
        use_fixed   = 1'b0;
        fixed_rdata = 16'h0;
        for (int g = 0; g < 2; g++) begin
            i_read[g] = 1'b0;         i_address[g] = 16'h0;
            d_read[g] = 1'b0;         d_write[g] = 1'b0;
            d_address[g] = 16'h0;     d_wdata[g] = 16'h0;
            d_byte_enable[g] = 2'b00;
            auto_en[g] = 1'b1;        man_resp[g] = 1'b0;
        end

        // reset state
        repeat (3) step();
        chk("rst_mem_read", 0, 16'(mem_read[0]), 16'h0);
        chk("rst_mem_address", 0, mem_address[0], 16'h0);
        chk("rst_d_resp", 1, 16'(d_resp[1]), 16'h0);
        rst_n = 1'b1;
        step();

        // single fetch, address change mid-wait must not disturb memory side
        use_fixed   = 1'b1;
        fixed_rdata = 16'h1234;
        i_read[0]   = 1'b1;
        i_address[0] = 16'h0040;
        step();
        chk("fetch_mem_read", 0, 16'(mem_read[0]), 16'h1);
        chk("fetch_mem_write", 0, 16'(mem_write[0]), 16'h0);
        chk("fetch_be", 0, 16'(mem_byte_enable[0]), 16'h3);
        chk("fetch_addr", 0, mem_address[0], 16'h0040);
        i_address[0] = 16'h0050;
        step();
        chk("fetch_addr_hold", 0, mem_address[0], 16'h0040);
        exp_resp(0, 1, 16'h1234, "fetch");
        i_read[0] = 1'b0;
        use_fixed = 1'b0;
        step();

        // round-robin with both held: D, I, D, I with an idle cycle between
        i_address[0] = 16'h0200; d_address[0] = 16'h0300;
        i_read[0] = 1'b1;        d_read[0] = 1'b1;
        exp_resp(0, 2, 16'hA6A5, "rr1");
        chk("rr_gap1", 0, 16'(mem_read[0]), 16'h0);
        exp_resp(0, 1, 16'hA7A5, "rr2");
        chk("rr_gap2", 0, 16'(mem_read[0]), 16'h0);
        exp_resp(0, 2, 16'hA6A5, "rr3");
        exp_resp(0, 1, 16'hA7A5, "rr4");
        i_read[0] = 1'b0; d_read[0] = 1'b0;
        step();

        // fixed data priority: data served twice, instruction only after data drops
        i_address[1] = 16'h0200; d_address[1] = 16'h0300;
        i_read[1] = 1'b1;        d_read[1] = 1'b1;
        exp_resp(1, 2, 16'hA6A5, "pri1");
        exp_resp(1, 2, 16'hA6A5, "pri2");
        d_read[1] = 1'b0;
        exp_resp(1, 1, 16'hA7A5, "pri3");
        i_read[1] = 1'b0;
        step();

        // data byte write, request inputs scrambled mid-wait
        d_write[0] = 1'b1; d_address[0] = 16'h0101;
        d_wdata[0] = 16'hAB00; d_byte_enable[0] = 2'b10;
        step();
        chk("dwr_mem_write", 0, 16'(mem_write[0]), 16'h1);
        chk("dwr_mem_read", 0, 16'(mem_read[0]), 16'h0);
        chk("dwr_be", 0, 16'(mem_byte_enable[0]), 16'h2);
        chk("dwr_addr", 0, mem_address[0], 16'h0101);
        chk("dwr_wdata", 0, mem_wdata[0], 16'hAB00);
        d_address[0] = 16'h0000; d_wdata[0] = 16'hFFFF; d_byte_enable[0] = 2'b01;
        step();
        chk("dwr_addr_hold", 0, mem_address[0], 16'h0101);
        chk("dwr_wdata_hold", 0, mem_wdata[0], 16'hAB00);
        chk("dwr_be_hold", 0, 16'(mem_byte_enable[0]), 16'h2);
        exp_resp(0, 2, 16'hA4A4, "dwr");
        d_write[0] = 1'b0;
        step();

        // read and write together are issued as a write
        d_read[0] = 1'b1; d_write[0] = 1'b1; d_address[0] = 16'h0222;
        d_wdata[0] = 16'h5555; d_byte_enable[0] = 2'b01;
        step();
        chk("rw_mem_write", 0, 16'(mem_write[0]), 16'h1);
        chk("rw_mem_read", 0, 16'(mem_read[0]), 16'h0);
        chk("rw_be", 0, 16'(mem_byte_enable[0]), 16'h1);
        exp_resp(0, 2, 16'hA787, "rw");
        d_read[0] = 1'b0; d_write[0] = 1'b0;
        step();

        // reset in the middle of a data write, then a stray mem_resp
        auto_en[0] = 1'b0;
        d_write[0] = 1'b1; d_address[0] = 16'h0444;
        d_wdata[0] = 16'h7777; d_byte_enable[0] = 2'b11;
        step();
        chk("mid_mem_write", 0, 16'(mem_write[0]), 16'h1);
        chk("mid_addr", 0, mem_address[0], 16'h0444);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_write", 0, 16'(mem_write[0]), 16'h0);
        chk("arst_addr", 0, mem_address[0], 16'h0);
        chk("arst_wdata", 0, mem_wdata[0], 16'h0);
        chk("arst_d_resp", 0, 16'(d_resp[0]), 16'h0);
        d_write[0] = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        man_resp[0] = 1'b1;
        #2;
        chk("late_d_resp", 0, 16'(d_resp[0]), 16'h0);
        chk("late_i_resp", 0, 16'(i_resp[0]), 16'h0);
        step();
        man_resp[0] = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single lc3b memory port between two requesters: an instruction-fetch port (read-only) and a data port (read/write).
- Sits between the CPU-side ports and physical memory: the CPU instruction path and data path on one side, the memory model on the other. This is the step toward split I/D caches.
- Captures the winning request into registers and drives memory from them until mem_resp.
- Routes the response back to the granted requester only.

Parameters:
- DATA_PRIORITY, 0, 0 = round-robin on simultaneous requests; 1 = data port always wins ties.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_read  in  1  instruction-port read request; held until i_resp.
- i_address  in  16  instruction address (lc3b_word).
- i_resp  out  1  one-cycle completion pulse to the instruction port.
- i_rdata  out  16  read data; valid only while i_resp=1.
- d_read  in  1  data-port read request; held until d_resp.
- d_write  in  1  data-port write request; held until d_resp.
- d_address  in  16  data address.
- d_wdata  in  16  write data.
- d_byte_enable  in  2  write mask (lc3b_mem_wmask).
- d_resp  out  1  one-cycle completion pulse to the data port.
- d_rdata  out  16  read data; valid only while d_resp=1.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  16  registered address.
- mem_wdata  out  16  registered write data.
- mem_byte_enable  out  2  registered mask.
- mem_resp  in  1  memory completion.
- mem_rdata  in  16  memory read data.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; last_grant goes to INST.
  - All outputs go to 0: mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, i_resp, d_resp, i_rdata, d_rdata.
  - Takes effect immediately, mid-transaction included. The in-flight access is abandoned, and no resp pulse is issued for it after reset is released.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Evaluates the requests; inst request = i_read, data request = d_read|d_write.
  - Neither requesting: stay in IDLE.
  - Only one requesting: go to that port's SERVE state.
  - Both requesting, DATA_PRIORITY=1: go to SERVE_D.
  - Both requesting, DATA_PRIORITY=0: grant the port not equal to last_grant.
  - On the grant edge: capture address, wdata and mask into registers, and update last_grant.
- Mask capture:
  - Instruction grant: mem_byte_enable=2'b11, mem_wdata=0.
  - Data read: mask=2'b11.
  - Data write: the d_byte_enable value is captured.
- d_read and d_write both high: treated as a write.
- SERVE_x:
  - Strobes: mem_read = (not a write); mem_write = write. Asserted every cycle in this state.
  - Registered address/data/mask are held stable, regardless of requester input changes.
- Completion (mem_resp=1 in SERVE_x):
  - The granted port's x_resp=1 in the same cycle, with x_rdata=mem_rdata passed combinationally.
  - The other port's resp=0 and rdata=0.
  - Next edge: go to IDLE and deassert the strobes.
- Latency:
  - Request first sampled in IDLE at edge k; strobe asserted in cycle k+1.
  - Minimum 1 idle cycle between back-to-back transactions; IDLE always lasts at least one cycle.
- mem_resp while in IDLE: ignored; no resp pulse.
- Request dropped while in SERVE: the transaction still completes. The resp pulse is still issued; the requester must tolerate it.
- Starvation: with DATA_PRIORITY=0, the maximum wait is one transaction.

Test Plan:
- Reset mid-transaction: d_write in flight (state SERVE_D), pulse rst_n low mid-cycle -> mem_write=0 and mem_address=0 immediately, no d_resp; a late mem_resp=1 after release produces no resp pulse.
- Single fetch: i_read=1, i_address=16'h0040, memory responds after 3 cycles with mem_rdata=16'h1234 -> mem_read=1, mem_byte_enable=2'b11, mem_address=16'h0040 from cycle 1; i_resp=1 with i_rdata=16'h1234 in the mem_resp cycle; d_resp=0 throughout.
- Data byte write: d_write=1, d_address=16'h0101, d_wdata=16'hAB00, d_byte_enable=2'b10 -> mem_write=1, mem_read=0, mask=2'b10, address and data held stable through the wait; d_resp one cycle.
- Simultaneous, round-robin: DATA_PRIORITY=0, last_grant=INST, i_read and d_read both held continuously -> grant order D, I, D, I with a 1 idle cycle gap each; rdata reaches only the granted port.
- Fixed priority: DATA_PRIORITY=1, both held for two transactions -> D served twice; i_resp stays 0 until d_read drops.
- Input change during serve: i_address changes from 16'h0040 to 16'h0050 mid-wait -> mem_address stays 16'h0040; d_read+d_write both high in IDLE -> issued as a write.
